// File: rtl/scope_pkg.sv
// Shared definitions for the scope capture path: state encoding and widths.
package scope_pkg;

   localparam int unsigned SCOPE_DATA_W = 12;
   localparam int unsigned SCOPE_ADDR_W = 10;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PRE       = 3'd1,
      ST_WAIT_TRIG = 3'd2,
      ST_POST      = 3'd3,
      ST_DONE      = 3'd4
   } scope_state_e;

   // States in which incoming samples are written to the sample RAM.
   function automatic logic is_capturing(input scope_state_e s);
      return (s == ST_PRE) || (s == ST_WAIT_TRIG) || (s == ST_POST);
   endfunction

endpackage

// File: rtl/scope_trig_detect.sv
// Level/slope trigger detector with forced-trigger latch.
// hit_o is combinational and only asserts on a sample that is being written
// while the sequencer waits for a trigger.
module scope_trig_detect
   import scope_pkg::*;
#(
   parameter int unsigned DATA_W = SCOPE_DATA_W
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear_i,
   input  logic              wr_i,
   input  logic              in_wait_i,
   input  logic              force_trig_i,
   input  logic [DATA_W-1:0] sample_i,
   input  logic [DATA_W-1:0] level_i,
   input  logic              rising_i,
   output logic              hit_o
);

   logic [DATA_W-1:0] prev_q, prev_d;
   logic              prev_valid_q, prev_valid_d;
   logic              force_q, force_d;
   logic              level_hit;

   // Slope crossing needs a previous sample written since arm.
   always_comb begin
      level_hit = 1'b0;
      if (prev_valid_q) begin
         if (rising_i) level_hit = (prev_q < level_i) && (sample_i >= level_i);
         else          level_hit = (prev_q > level_i) && (sample_i <= level_i);
      end
      hit_o = wr_i && in_wait_i && (level_hit || force_q || force_trig_i);
   end

   // Next values for the previous-sample history and the force latch.
   always_comb begin
      prev_d       = prev_q;
      prev_valid_d = prev_valid_q;
      if (clear_i) begin
         prev_valid_d = 1'b0;
      end else if (wr_i) begin
         prev_d       = sample_i;
         prev_valid_d = 1'b1;
      end
      // A force request is only remembered while waiting and until it fires.
      force_d = in_wait_i && !hit_o && (force_q || force_trig_i);
   end

   // Detector state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         force_q      <= 1'b0;
      end else begin
         prev_q       <= prev_d;
         prev_valid_q <= prev_valid_d;
         force_q      <= force_d;
      end
   end

endmodule

// File: rtl/scope_capture_ctrl.sv
// Capture sequencer: fills a circular sample RAM with a pre-trigger window,
// waits for a trigger, completes the post-trigger window and reports the
// record start and trigger addresses.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | no capture; arm latches config and starts one
//   PRE        | writing the pre-trigger window (down-counter cnt_q)
//   WAIT_TRIG  | writing samples while looking for a trigger
//   POST       | writing the post-trigger window (down-counter cnt_q)
//   DONE       | record complete; outputs hold until arm or abort
module scope_capture_ctrl
   import scope_pkg::*;
#(
   parameter int unsigned DATA_W = SCOPE_DATA_W,
   parameter int unsigned ADDR_W = SCOPE_ADDR_W
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              arm,
   input  logic              abort,
   input  logic              force_trig,
   input  logic [DATA_W-1:0] trig_level,
   input  logic              trig_rising,
   input  logic [ADDR_W-1:0] pretrig,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic [2:0]        state,
   output logic [ADDR_W-1:0] trig_addr,
   output logic [ADDR_W-1:0] start_addr
);

   scope_state_e      state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] pretrig_q, pretrig_d;
   logic [DATA_W-1:0] level_q, level_d;
   logic              rising_q, rising_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
   logic [ADDR_W-1:0] start_addr_q, start_addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic accept;
   logic arm_ok;
   logic trig_hit;

   // abort wins over everything, so it also suppresses the write and re-arm.
   always_comb begin
      accept = sample_valid && !abort && is_capturing(state_q);
      arm_ok = arm && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   end

   scope_trig_detect #(
      .DATA_W (DATA_W)
   ) u_trig (
      .clk          (clk),
      .reset_n      (reset_n),
      .clear_i      (arm_ok),
      .wr_i         (accept),
      .in_wait_i    ((state_q == ST_WAIT_TRIG) && !abort),
      .force_trig_i (force_trig),
      .sample_i     (sample_data),
      .level_i      (level_q),
      .rising_i     (rising_q),
      .hit_o        (trig_hit)
   );

   // Sequencer next state, pointer/counter updates and registered outputs.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      pretrig_d    = pretrig_q;
      level_d      = level_q;
      rising_d     = rising_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      trig_addr_d  = trig_addr_q;
      start_addr_d = start_addr_q;

      if (accept) begin
         wr_en_d   = 1'b1;
         wr_addr_d = ptr_q;
         wr_data_d = sample_data;
         ptr_d     = ptr_q + 1'b1;
      end

      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (arm) begin
                  pretrig_d = pretrig;
                  level_d   = trig_level;
                  rising_d  = trig_rising;
                  ptr_d     = '0;
                  cnt_d     = pretrig;
                  state_d   = (pretrig == '0) ? ST_WAIT_TRIG : ST_PRE;
               end
            end
            ST_PRE: begin
               if (accept) begin
                  cnt_d = cnt_q - 1'b1;
                  if (cnt_q == ADDR_W'(1)) state_d = ST_WAIT_TRIG;
               end
            end
            ST_WAIT_TRIG: begin
               if (trig_hit) begin
                  trig_addr_d  = ptr_q;
                  start_addr_d = ptr_q - pretrig_q;
                  // Post window length DEPTH-1-pretrig is the bitwise inverse.
                  cnt_d        = ~pretrig_q;
                  state_d      = (pretrig_q == '1) ? ST_DONE : ST_POST;
               end
            end
            ST_POST: begin
               if (accept) begin
                  cnt_d = cnt_q - 1'b1;
                  if (cnt_q == ADDR_W'(1)) state_d = ST_DONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = is_capturing(state_d);
      done_d = (state_d == ST_DONE);
   end

   // Sequencer and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         cnt_q        <= '0;
         pretrig_q    <= '0;
         level_q      <= '0;
         rising_q     <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         trig_addr_q  <= '0;
         start_addr_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         pretrig_q    <= pretrig_d;
         level_q      <= level_d;
         rising_q     <= rising_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         trig_addr_q  <= trig_addr_d;
         start_addr_q <= start_addr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign state      = state_q;
   assign trig_addr  = trig_addr_q;
   assign start_addr = start_addr_q;

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Bench for scope_capture_ctrl with a 16-entry record.
module tb_scope_capture_ctrl;

   localparam int DW    = 12;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          sample_valid = 1'b0;
   logic [DW-1:0] sample_data = '0;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic          force_trig = 1'b0;
   logic [DW-1:0] trig_level = '0;
   logic          trig_rising = 1'b0;
   logic [AW-1:0] pretrig = '0;
   logic          wr_en, busy, done;
   logic [AW-1:0] wr_addr, trig_addr, start_addr;
   logic [DW-1:0] wr_data;
   logic [2:0]    state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] smp [0:127];
   logic [AW-1:0] log_addr [$];
   logic [DW-1:0] log_data [$];
   int            done_rises = 0;
   bit            done_prev = 1'b0;
   bit            done_rise_wr = 1'b0;

   always #5 clk = ~clk;

   scope_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .arm          (arm),
      .abort        (abort),
      .force_trig   (force_trig),
      .trig_level   (trig_level),
      .trig_rising  (trig_rising),
      .pretrig      (pretrig),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .busy         (busy),
      .done         (done),
      .state        (state),
      .trig_addr    (trig_addr),
      .start_addr   (start_addr)
   );

   // RAM write monitor and done-edge tracker, sampled mid-cycle.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         log_addr.push_back(wr_addr);
         log_data.push_back(wr_data);
      end
      done_prev <= (done === 1'b1);
      if (done === 1'b1 && !done_prev) begin
         done_rises   <= done_rises + 1;
         done_rise_wr <= (wr_en === 1'b1);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_ramp(input int start, input int step);
      for (int i = 0; i < 128; i++) smp[i] = DW'(start + step * i);
   endtask

   task automatic fill_const(input logic [DW-1:0] v);
      for (int i = 0; i < 128; i++) smp[i] = v;
   endtask

   task automatic abort_pulse();
      abort = 1'b1;
      tick();
      abort = 1'b0;
   endtask

   // Arms a capture, streams smp[0..n-1] and checks against the record model.
   task automatic run_capture(input string name, input int pre, input logic [DW-1:0] lvl,
                              input bit rise, input int n, input int fa, input int fb,
                              input int arm_at, input int gap_max);
      int base, rises0, t, nw_exp, got_n, bad_i;
      bit done_exp, lh, fh;
      base   = log_addr.size();
      rises0 = done_rises;

      // Model: first sample at/after the pre window that crosses or is forced.
      t = -1;
      for (int k = pre; k < n && t < 0; k++) begin
         lh = (k >= 1) && (rise ? (smp[k-1] < lvl && smp[k] >= lvl)
                                : (smp[k-1] > lvl && smp[k] <= lvl));
         fh = (fa >= pre && k >= fa) || (fb >= pre && k >= fb);
         if (lh || fh) t = k;
      end
      done_exp = (t >= 0) && (t + DEPTH - pre <= n);
      nw_exp   = done_exp ? (t + DEPTH - pre) : n;

      pretrig     = AW'(pre);
      trig_level  = lvl;
      trig_rising = rise;
      arm         = 1'b1;
      tick();
      arm = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || state !== ((pre == 0) ? 3'd2 : 3'd1)) begin
         n_fail++;
         $display("FAIL %s arm: busy=%b state=%0d, expected busy=1 state=%0d",
                  name, busy, state, (pre == 0) ? 2 : 1);
      end
      // Config must already be latched; scramble the live inputs.
      trig_level  = DW'($urandom);
      trig_rising = ~rise;
      pretrig     = AW'($urandom);

      for (int i = 0; i < n; i++) begin
         if (done === 1'b1) break;
         if (i == fa || i == fb) begin
            force_trig = 1'b1;
            tick();
            force_trig = 1'b0;
         end
         if (i == arm_at) begin
            arm = 1'b1;
            tick();
            arm = 1'b0;
         end
         repeat ($urandom_range(gap_max, 0)) tick();
         sample_valid = 1'b1;
         sample_data  = smp[i];
         tick();
         sample_valid = 1'b0;
      end
      if (done === 1'b1) begin
         // DONE must ignore further samples and force requests.
         sample_valid = 1'b1;
         force_trig   = 1'b1;
         sample_data  = DW'($urandom);
         repeat (3) tick();
         sample_valid = 1'b0;
         force_trig   = 1'b0;
      end
      tick();
      tick();

      got_n = log_addr.size() - base;
      n_checks++;
      if (got_n != nw_exp) begin
         n_fail++;
         $display("FAIL %s write_count: got %0d, expected %0d", name, got_n, nw_exp);
      end
      bad_i = -1;
      for (int i = 0; i < got_n && i < nw_exp; i++)
         if (bad_i < 0 && (log_addr[base+i] !== AW'(i) || log_data[base+i] !== smp[i])) bad_i = i;
      n_checks++;
      if (bad_i >= 0) begin
         n_fail++;
         $display("FAIL %s write[%0d]: got addr=%0d data=%h, expected addr=%0d data=%h", name,
                  bad_i, log_addr[base+bad_i], log_data[base+bad_i], bad_i % DEPTH, smp[bad_i]);
      end
      n_checks++;
      if (done !== done_exp || busy !== !done_exp) begin
         n_fail++;
         $display("FAIL %s status: got done=%b busy=%b, expected done=%b busy=%b",
                  name, done, busy, done_exp, !done_exp);
      end
      if (t >= 0) begin
         n_checks++;
         if (trig_addr !== AW'(t) || start_addr !== AW'(t - pre)) begin
            n_fail++;
            $display("FAIL %s addrs: got trig=%0d start=%0d, expected trig=%0d start=%0d",
                     name, trig_addr, start_addr, AW'(t), AW'(t - pre));
         end
      end
      if (done_exp) begin
         n_checks++;
         if (done_rises != rises0 + 1 || !done_rise_wr || state !== 3'd4) begin
            n_fail++;
            $display("FAIL %s done_edge: got rises=%0d with_wr=%b state=%0d, expected rises=%0d with_wr=1 state=4",
                     name, done_rises - rises0, done_rise_wr, state, 1);
         end
      end
   endtask

   // Feeds the ramp in smp until the sequencer reaches POST (bounded).
   task automatic arm_and_reach_post(input string name);
      pretrig     = AW'(2);
      trig_level  = 12'h800;
      trig_rising = 1'b1;
      arm         = 1'b1;
      tick();
      arm = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (state === 3'd3) break;
         sample_valid = 1'b1;
         sample_data  = smp[i];
         tick();
         sample_valid = 1'b0;
      end
      n_checks++;
      if (state !== 3'd3) begin
         n_fail++;
         $display("FAIL %s reach_post: got state=%0d, expected 3", name, state);
      end
   endtask

   task automatic test_reset();
      int base;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({wr_en, busy, done, state, wr_addr, wr_data, trig_addr, start_addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_values: got wr_en=%b busy=%b done=%b state=%0d wr_addr=%0d wr_data=%h trig=%0d start=%0d, expected all 0",
                  wr_en, busy, done, state, wr_addr, wr_data, trig_addr, start_addr);
      end
      reset_n = 1'b1;
      tick();
      base = log_addr.size();
      sample_valid = 1'b1;
      force_trig   = 1'b1;
      sample_data  = 12'hABC;
      repeat (4) tick();
      sample_valid = 1'b0;
      force_trig   = 1'b0;
      tick();
      n_checks++;
      if (log_addr.size() != base || state !== 3'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_write: got writes=%0d state=%0d busy=%b, expected writes=0 state=0 busy=0",
                  log_addr.size() - base, state, busy);
      end
   endtask

   task automatic test_rising_basic();
      fill_ramp(0, 'h100);
      run_capture("rising_basic", 4, 12'h800, 1'b1, 30, -1, -1, -1, 0);
   endtask

   task automatic test_falling_wrap();
      for (int i = 0; i < 128; i++) smp[i] = DW'($urandom);
      for (int i = 0; i < 20; i++) smp[i] = DW'(12'h900 + $urandom_range(12'h6FF, 0));
      smp[20] = 12'h700;
      run_capture("falling_wrap", 3, 12'h800, 1'b0, 40, -1, -1, -1, 2);
   endtask

   task automatic test_pretrig_edges();
      fill_ramp(0, 'h100);
      run_capture("pretrig_zero", 0, 12'h500, 1'b1, 30, -1, -1, -1, 1);
      fill_ramp(0, 'h80);
      run_capture("pretrig_max", 15, 12'h800, 1'b1, 30, -1, -1, -1, 1);
   endtask

   task automatic test_force();
      fill_const(12'h123);
      run_capture("force_pre_then_wait", 5, 12'h123, 1'b1, 30, 2, 9, -1, 1);
      run_capture("force_first_eq_level", 0, 12'h123, 1'b1, 30, -1, 4, -1, 0);
   endtask

   task automatic test_arm_ignored();
      fill_ramp('hF00, -'h100);
      run_capture("arm_in_wait", 4, 12'h800, 1'b0, 30, -1, -1, 5, 1);
   endtask

   task automatic test_abort_post();
      fill_ramp(0, 'h100);
      arm_and_reach_post("abort_post");
      abort        = 1'b1;
      sample_valid = 1'b1;
      sample_data  = 12'hFFF;
      tick();
      abort        = 1'b0;
      sample_valid = 1'b0;
      n_checks++;
      if (state !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_post: got state=%0d busy=%b done=%b wr_en=%b, expected 0 0 0 0",
                  state, busy, done, wr_en);
      end
   endtask

   task automatic test_reset_mid_post();
      fill_ramp(0, 'h100);
      arm_and_reach_post("reset_mid_post");
      sample_valid = 1'b1;
      sample_data  = 12'h5A5;
      tick();
      sample_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({wr_en, busy, done, state, wr_addr, wr_data, trig_addr, start_addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_post: got wr_en=%b busy=%b done=%b state=%0d wr_addr=%0d wr_data=%h trig=%0d start=%0d, expected all 0",
                  wr_en, busy, done, state, wr_addr, wr_data, trig_addr, start_addr);
      end
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_rearm_from_done();
      fill_ramp(0, 'h100);
      run_capture("rearm_first", 6, 12'h600, 1'b1, 30, -1, -1, -1, 1);
      fill_ramp('hF00, -'h80);
      run_capture("rearm_second", 9, 12'hA00, 1'b0, 40, -1, -1, -1, 1);
   endtask

   task automatic test_random();
      int pre, fa, arm_at;
      logic [DW-1:0] lvl;
      bit rise;
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < 128; i++) smp[i] = DW'($urandom);
         pre    = $urandom_range(15, 0);
         lvl    = DW'($urandom);
         rise   = 1'($urandom_range(1, 0));
         fa     = ($urandom_range(1, 0) != 0) ? int'($urandom_range(40, 0)) : -1;
         arm_at = ($urandom_range(1, 0) != 0) ? int'($urandom_range(30, 0)) : -1;
         run_capture($sformatf("random_%0d", it), pre, lvl, rise, 50, fa, -1, arm_at, 2);
         if (done !== 1'b1) abort_pulse();
      end
   endtask

   initial begin
      test_reset();
      test_rising_basic();
      test_falling_wrap();
      test_pretrig_edges();
      test_force();
      test_arm_ignored();
      test_abort_post();
      test_reset_mid_post();
      test_rearm_from_done();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
